// File: rtl/trig_pkg.sv
// Shared encodings for the channel trigger bank: per-channel mode codes and FSM states.
// Latency: n/a; backpressure: n/a.
package trig_pkg;

    localparam int CFG_W = 3;

    typedef enum logic [CFG_W-1:0] {
        MODE_DISABLED   = 3'd0,
        MODE_LEVEL_HIGH = 3'd1,
        MODE_LEVEL_LOW  = 3'd2,
        MODE_RISE       = 3'd3,
        MODE_FALL       = 3'd4
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } trig_state_e;

endpackage

// File: rtl/chan_trig_match.sv
// One channel: previous-sample edge detect, live level/edge match and sticky edge latch.
// Latency: match is combinational from the current sample; backpressure: none.
module chan_trig_match
    import trig_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wrt_smpl,
    input  logic             chh,
    input  logic             chl,
    input  logic [CFG_W-1:0] mode,
    input  logic             sticky_en,
    input  logic             sticky_clr,
    output logic             enabled,
    output logic             match
);

    logic prev_chh;
    logic prev_chl;
    logic sticky;
    logic level_hit;
    logic edge_hit;

    // Reserved codes 5-7 fall into the default arm and act as disabled.
    always_comb begin
        level_hit = 1'b0;
        edge_hit  = 1'b0;
        enabled   = 1'b1;
        case (mode)
            MODE_LEVEL_HIGH: level_hit = chh;
            MODE_LEVEL_LOW:  level_hit = ~chl;
            MODE_RISE:       edge_hit  = chh & ~prev_chh;
            MODE_FALL:       edge_hit  = ~chl & prev_chl;
            default:         enabled   = 1'b0;
        endcase
        match = enabled & (level_hit | edge_hit | sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_chh <= 1'b0;
            prev_chl <= 1'b0;
            sticky   <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                prev_chh <= chh;
                prev_chl <= chl;
            end
            if (sticky_clr) begin
                sticky <= 1'b0;
            end else if (sticky_en && wrt_smpl && edge_hit) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_trigger_bank.sv
// Multi-channel trigger: combines per-channel matches (AND/OR), then counts post-trigger samples.
// Latency: trigger sample at edge N shows as triggered=1 after edge N; backpressure: none.
module channel_trigger_bank
    import trig_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wrt_smpl,
    input  logic [NUM_CH-1:0]       chh,
    input  logic [NUM_CH-1:0]       chl,
    input  logic [CFG_W*NUM_CH-1:0] ch_cfg,
    input  logic                    comb_and,
    input  logic                    set_armed,
    input  logic                    clr_trig,
    input  logic [CNT_W-1:0]        trig_pos,
    output logic                    armed,
    output logic                    triggered,
    output logic                    capture_done,
    output logic [NUM_CH-1:0]       trig_src,
    output logic [CNT_W-1:0]        post_cnt
);

    trig_state_e       state;
    logic [NUM_CH-1:0] en_vec;
    logic [NUM_CH-1:0] match_vec;
    logic [NUM_CH-1:0] en_hits;
    logic              trig_hit;
    logic              arm_entry;
    logic              sticky_en;
    logic [CNT_W-1:0]  post_inc;

    // Sticky bits are cleared on the same edge that enters ARMED, so stale edges never count.
    assign sticky_en = (state == ST_ARMED);
    assign arm_entry = set_armed && !clr_trig && ((state == ST_IDLE) || (state == ST_DONE));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_trig_match u_match (
            .clk        (clk),
            .rst        (rst),
            .wrt_smpl   (wrt_smpl),
            .chh        (chh[i]),
            .chl        (chl[i]),
            .mode       (ch_cfg[CFG_W*i +: CFG_W]),
            .sticky_en  (sticky_en),
            .sticky_clr (arm_entry),
            .enabled    (en_vec[i]),
            .match      (match_vec[i])
        );
    end

    assign en_hits  = match_vec & en_vec;
    assign trig_hit = wrt_smpl && (comb_and ? ((|en_vec) && (en_hits == en_vec)) : (|en_hits));
    assign post_inc = (post_cnt == {CNT_W{1'b1}}) ? post_cnt : post_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            trig_src     <= '0;
            post_cnt     <= '0;
        end else if (clr_trig) begin
            state        <= ST_IDLE;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            trig_src     <= '0;
            post_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (set_armed) begin
                        state <= ST_ARMED;
                        armed <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        state     <= ST_TRIGGERED;
                        armed     <= 1'b0;
                        triggered <= 1'b1;
                        trig_src  <= en_hits;
                        post_cnt  <= '0;
                    end
                end
                ST_TRIGGERED: begin
                    // A zero-length capture finishes on the first clock, strobe or not.
                    if (trig_pos == '0) begin
                        state        <= ST_DONE;
                        capture_done <= 1'b1;
                    end else if (wrt_smpl) begin
                        post_cnt <= post_inc;
                        if (post_inc == trig_pos) begin
                            state        <= ST_DONE;
                            capture_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (set_armed) begin
                        state        <= ST_ARMED;
                        armed        <= 1'b1;
                        triggered    <= 1'b0;
                        capture_done <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    armed        <= 1'b0;
                    triggered    <= 1'b0;
                    capture_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/channel_trigger_bank.md
CHANNEL_TRIGGER_BANK -- requirements
Module: channel_trigger_bank

Interface
REQ-001 Parameter NUM_CH, default 5: number of sampled channels.
REQ-002 Parameter CNT_W, default 9: width of the post-trigger sample counter.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wrt_smpl  input  1  decimated sample strobe; all trigger evaluation is qualified by it.
REQ-006 chh  input  NUM_CH  per-channel high-threshold comparator output, already synchronized.
REQ-007 chl  input  NUM_CH  per-channel low-threshold comparator output, already synchronized.
REQ-008 ch_cfg  input  3*NUM_CH  per-channel trigger mode; channel i occupies bits [3i+2:3i].
REQ-009 comb_and  input  1  1 = AND of enabled channels; 0 = OR.
REQ-010 set_armed  input  1  single-cycle arm request.
REQ-011 clr_trig  input  1  single-cycle abort/clear request.
REQ-012 trig_pos  input  CNT_W  number of post-trigger samples to collect.
REQ-013 armed  output  1  state is ARMED.
REQ-014 triggered  output  1  state is TRIGGERED or DONE.
REQ-015 capture_done  output  1  state is DONE.
REQ-016 trig_src  output  NUM_CH  per-channel match vector frozen at the trigger sample.
REQ-017 post_cnt  output  CNT_W  post-trigger samples counted.

Function
REQ-018 Mode encoding: 0 DISABLED, 1 LEVEL_HIGH, 2 LEVEL_LOW, 3 RISE, 4 FALL; codes 5-7 SHALL behave as DISABLED.
REQ-019 prev_chh/prev_chl SHALL update on every wrt_smpl cycle in every state.
REQ-020 On a wrt_smpl cycle: LEVEL_HIGH matches when chh=1; LEVEL_LOW when chl=0; RISE when chh=1 and prev_chh=0; FALL when chl=0 and prev_chl=1.
REQ-021 Edge matches SHALL latch sticky per channel while ARMED; sticky bits clear on entry to ARMED and on rst; level matches are live.
REQ-022 Combined condition: AND mode requires every enabled channel matched (live or sticky); OR mode requires any; zero enabled channels SHALL never trigger.
REQ-023 FSM states IDLE, ARMED, TRIGGERED, DONE.
REQ-024 IDLE -> ARMED on set_armed.
REQ-025 ARMED -> TRIGGERED on a wrt_smpl cycle where the combined condition holds; trig_src captured and post_cnt cleared on the same edge.
REQ-026 In TRIGGERED, post_cnt SHALL increment on each subsequent wrt_smpl; TRIGGERED -> DONE on the edge post_cnt becomes equal to trig_pos.
REQ-027 trig_pos=0: TRIGGERED -> DONE on the first clock after entering TRIGGERED, regardless of wrt_smpl.
REQ-028 post_cnt SHALL saturate at all-ones, never wrap.
REQ-029 DONE -> ARMED on set_armed (re-arm, sticky bits cleared); trig_src and post_cnt hold until then.
REQ-030 clr_trig SHALL force IDLE from any state next clock, with priority over set_armed and the trigger condition.
REQ-031 set_armed while ARMED or TRIGGERED SHALL be ignored.
REQ-032 All outputs registered; trigger sample at cycle N -> triggered=1 at N+1.

Reset
REQ-033 rst SHALL force IDLE; armed, triggered, capture_done = 0; trig_src, post_cnt, sticky bits, prev_chh, prev_chl = 0.
REQ-034 rst SHALL take priority over every other input, including mid-capture.

Structure
REQ-035 Mode enum, state enum and the 3-bit cfg width SHALL live in a shared package trig_pkg.
REQ-036 Per-channel edge detect, match and sticky logic SHALL be one sub-module, chan_trig_match, instantiated NUM_CH times by generate.

Verification
REQ-037 cfg ch0=RISE, others DISABLED, OR; arm; ch0 chh 0->1 on a strobe -> triggered=1 next clock, trig_src=5'b00001.
REQ-038 AND, ch1=RISE, ch3=FALL; ch1 rises sample 3, ch3 falls sample 7 -> trigger at sample 7 only, trig_src=5'b01010.
REQ-039 trig_pos=4, trigger fires -> capture_done=1 after 4th post-trigger strobe, post_cnt=4; non-strobe cycles do not count.
REQ-040 trig_pos=0 -> capture_done=1 one clock after triggered=1.
REQ-041 clr_trig and set_armed same cycle while TRIGGERED -> IDLE, all status outputs 0; rst mid-TRIGGERED -> REQ-033 values.
REQ-042 All channels cfg=6 (reserved) with chh toggling, OR mode -> never triggers over 100 strobes.
